// File: rtl/reorder01_if.sv
// Bus bundle between the stage-1 butterflies and the stage-2 reorder buffer.
// The master drives input beats and reads the reordered operand pairs.
interface reorder01_if #(
    parameter int WIDTH = 10
);
    logic                    din_en;
    logic                    clr;
    logic signed [WIDTH:0]   din1_i [0:15];
    logic signed [WIDTH:0]   din1_q [0:15];
    logic signed [WIDTH:0]   din2_i [0:15];
    logic signed [WIDTH:0]   din2_q [0:15];
    logic signed [WIDTH:0]   dout1_i [0:15];
    logic signed [WIDTH:0]   dout1_q [0:15];
    logic signed [WIDTH:0]   dout2_i [0:15];
    logic signed [WIDTH:0]   dout2_q [0:15];
    logic                    dout_en;

    modport master (
        output din_en, clr, din1_i, din1_q, din2_i, din2_q,
        input  dout1_i, dout1_q, dout2_i, dout2_q, dout_en
    );

    modport slave (
        input  din_en, clr, din1_i, din1_q, din2_i, din2_q,
        output dout1_i, dout1_q, dout2_i, dout2_q, dout_en
    );
endinterface

// File: rtl/reorder01.sv
// Ping-pong reorder buffer: collects 4 beats of butterfly sums/differences and
// replays them as (A0,A1),(A2,A3),(S0,S1),(S2,S3) operand pairs.
module reorder01 #(
    parameter int INT   = 4,
    parameter int FLT   = 6,
    parameter int WIDTH = INT + FLT
) (
    input  logic       clk,
    input  logic       rstn,
    reorder01_if.slave bus
);
    typedef logic signed [WIDTH:0] sample_t;
    typedef enum logic {IDLE, READ} state_t;

    // Storage indexed [bank][beat][lane].
    sample_t mem_a_i_q [2][4][16];
    sample_t mem_a_q_q [2][4][16];
    sample_t mem_s_i_q [2][4][16];
    sample_t mem_s_q_q [2][4][16];

    logic [1:0] wcnt_q, wcnt_d;
    logic       wbank_q, wbank_d;
    logic [1:0] full_q, full_d;
    state_t     state_q, state_d;
    logic [1:0] rcnt_q, rcnt_d;
    logic       rbank_q, rbank_d;
    logic       accept, blk_done;

    sample_t dout1_i_q [16], dout1_i_d [16];
    sample_t dout1_q_q [16], dout1_q_d [16];
    sample_t dout2_i_q [16], dout2_i_d [16];
    sample_t dout2_q_q [16], dout2_q_d [16];
    logic    dout_en_q, dout_en_d;

    logic [1:0] idx_lo, idx_hi;

    assign accept   = bus.din_en && !bus.clr;
    assign blk_done = accept && (wcnt_q == 2'd3);

    // NOTE: bank storage carries no reset; a bank only reaches the outputs
    // after all four of its beats have been written since reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int l = 0; l < 16; l++) begin
                mem_a_i_q[wbank_q][wcnt_q][l] <= bus.din1_i[l];
                mem_a_q_q[wbank_q][wcnt_q][l] <= bus.din1_q[l];
                mem_s_i_q[wbank_q][wcnt_q][l] <= bus.din2_i[l];
                mem_s_q_q[wbank_q][wcnt_q][l] <= bus.din2_q[l];
            end
        end
    end

    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        full_d  = full_q;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;

        if (bus.clr) begin
            wcnt_d = 2'd0;
        end else if (accept) begin
            wcnt_d = wcnt_q + 2'd1;
        end
        if (blk_done) begin
            wbank_d = ~wbank_q;
        end

        if (state_q == READ && rcnt_q == 2'd3) begin
            full_d[rbank_q] = 1'b0;
        end
        if (blk_done) begin
            full_d[wbank_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (blk_done) begin
                    state_d = READ;
                    rcnt_d  = 2'd0;
                    rbank_d = wbank_q;
                end
            end
            READ: begin
                if (rcnt_q == 2'd3) begin
                    // A bank completing on the last read cycle continues seamlessly.
                    if (blk_done || full_q[~rbank_q]) begin
                        rcnt_d  = 2'd0;
                        rbank_d = ~rbank_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rcnt_d = rcnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next state, so the pair for rcnt=0 is
    // already on the lanes in the first READ cycle.
    assign idx_lo = {rcnt_d[0], 1'b0};
    assign idx_hi = {rcnt_d[0], 1'b1};

    always_comb begin
        dout_en_d = (state_d == READ);
        for (int l = 0; l < 16; l++) begin
            dout1_i_d[l] = '0;
            dout1_q_d[l] = '0;
            dout2_i_d[l] = '0;
            dout2_q_d[l] = '0;
            if (state_d == READ) begin
                if (rcnt_d[1]) begin
                    dout1_i_d[l] = mem_s_i_q[rbank_d][idx_lo][l];
                    dout1_q_d[l] = mem_s_q_q[rbank_d][idx_lo][l];
                    dout2_i_d[l] = mem_s_i_q[rbank_d][idx_hi][l];
                    dout2_q_d[l] = mem_s_q_q[rbank_d][idx_hi][l];
                end else begin
                    dout1_i_d[l] = mem_a_i_q[rbank_d][idx_lo][l];
                    dout1_q_d[l] = mem_a_q_q[rbank_d][idx_lo][l];
                    dout2_i_d[l] = mem_a_i_q[rbank_d][idx_hi][l];
                    dout2_q_d[l] = mem_a_q_q[rbank_d][idx_hi][l];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q    <= 2'd0;
            wbank_q   <= 1'b0;
            full_q    <= 2'b00;
            state_q   <= IDLE;
            rcnt_q    <= 2'd0;
            rbank_q   <= 1'b0;
            dout_en_q <= 1'b0;
            for (int l = 0; l < 16; l++) begin
                dout1_i_q[l] <= '0;
                dout1_q_q[l] <= '0;
                dout2_i_q[l] <= '0;
                dout2_q_q[l] <= '0;
            end
        end else begin
            wcnt_q    <= wcnt_d;
            wbank_q   <= wbank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            rbank_q   <= rbank_d;
            dout_en_q <= dout_en_d;
            for (int l = 0; l < 16; l++) begin
                dout1_i_q[l] <= dout1_i_d[l];
                dout1_q_q[l] <= dout1_q_d[l];
                dout2_i_q[l] <= dout2_i_d[l];
                dout2_q_q[l] <= dout2_q_d[l];
            end
        end
    end

    assign bus.dout_en = dout_en_q;
    always_comb begin
        for (int l = 0; l < 16; l++) begin
            bus.dout1_i[l] = dout1_i_q[l];
            bus.dout1_q[l] = dout1_q_q[l];
            bus.dout2_i[l] = dout2_i_q[l];
            bus.dout2_q[l] = dout2_q_q[l];
        end
    end
endmodule

// File: tb/tb_reorder01.sv
// Randomized bench for reorder01 against a block-level queue model of the
// expected output pairs.
module tb_reorder01;
    localparam int W = 10;

    typedef logic [15:0][W:0] lanes_t;
    typedef struct packed {
        lanes_t o1i, o1q, o2i, o2q;
    } pair_t;

    logic clk;
    logic rstn;
    reorder01_if #(.WIDTH(W)) bus ();

    reorder01 dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    lanes_t b1i, b1q, b2i, b2q;
    lanes_t ma1i [4], ma1q [4], ma2i [4], ma2q [4];
    int     mw = 0;
    pair_t  exp_q [$];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rand_beat();
        for (int l = 0; l < 16; l++) begin
            b1i[l] = (W+1)'($urandom);
            b1q[l] = (W+1)'($urandom);
            b2i[l] = (W+1)'($urandom);
            b2q[l] = (W+1)'($urandom);
        end
    endtask

    task automatic push_pair(input lanes_t ui, input lanes_t uq, input lanes_t vi, input lanes_t vq);
        pair_t p;
        p.o1i = ui;
        p.o1q = uq;
        p.o2i = vi;
        p.o2q = vq;
        exp_q.push_back(p);
    endtask

    task automatic model_edge(input logic en, input logic c);
        if (c) begin
            mw = 0;
        end else if (en) begin
            ma1i[mw] = b1i;
            ma1q[mw] = b1q;
            ma2i[mw] = b2i;
            ma2q[mw] = b2q;
            mw++;
            if (mw == 4) begin
                push_pair(ma1i[0], ma1q[0], ma1i[1], ma1q[1]);
                push_pair(ma1i[2], ma1q[2], ma1i[3], ma1q[3]);
                push_pair(ma2i[0], ma2q[0], ma2i[1], ma2q[1]);
                push_pair(ma2i[2], ma2q[2], ma2i[3], ma2q[3]);
                mw = 0;
            end
        end
    endtask

    task automatic compare();
        pair_t e;
        logic  en_exp;
        if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            en_exp = 1'b1;
        end else begin
            e      = '0;
            en_exp = 1'b0;
        end
        check("dout_en", longint'(bus.dout_en), longint'(en_exp));
        for (int l = 0; l < 16; l++) begin
            check($sformatf("dout1_i[%0d]", l), bus.dout1_i[l], $signed(e.o1i[l]));
            check($sformatf("dout1_q[%0d]", l), bus.dout1_q[l], $signed(e.o1q[l]));
            check($sformatf("dout2_i[%0d]", l), bus.dout2_i[l], $signed(e.o2i[l]));
            check($sformatf("dout2_q[%0d]", l), bus.dout2_q[l], $signed(e.o2q[l]));
        end
    endtask

    task automatic step(input logic en, input logic c);
        @(negedge clk);
        bus.din_en = en;
        bus.clr    = c;
        for (int l = 0; l < 16; l++) begin
            bus.din1_i[l] = b1i[l];
            bus.din1_q[l] = b1q[l];
            bus.din2_i[l] = b2i[l];
            bus.din2_q[l] = b2q[l];
        end
        @(posedge clk);
        model_edge(en, c);
        #1 compare();
    endtask

    task automatic beat(input int a0, input int s0);
        rand_beat();
        b1i[0] = (W+1)'(a0);
        b2i[0] = (W+1)'(s0);
        step(1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rand_beat();
            step(1'b0, 1'b0);
        end
    endtask

    task automatic rand_beats(input int n);
        for (int i = 0; i < n; i++) begin
            rand_beat();
            step(1'b1, 1'b0);
        end
    endtask

    // Called just after a compare, well clear of both clock edges.
    task automatic pulse_reset();
        #1;
        rstn       = 1'b0;
        bus.din_en = 1'b0;
        bus.clr    = 1'b0;
        exp_q.delete();
        mw = 0;
        #1 compare();
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn       = 1'b0;
        bus.din_en = 1'b0;
        bus.clr    = 1'b0;
        b1i = '0; b1q = '0; b2i = '0; b2q = '0;
        for (int l = 0; l < 16; l++) begin
            bus.din1_i[l] = '0;
            bus.din1_q[l] = '0;
            bus.din2_i[l] = '0;
            bus.din2_q[l] = '0;
        end
        #3 compare();
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // Contiguous directed block.
        beat(1, -1); beat(2, -2); beat(3, -3); beat(4, -4);
        idle(5);

        // Back-to-back blocks across both banks.
        rand_beats(8);
        idle(5);

        // Gapped input pattern 1,0,0,1,1,0,1.
        beat(1, -1); idle(2); beat(2, -2); beat(3, -3); idle(1); beat(4, -4);
        idle(5);

        // clr after two beats drops them and the clr-edge beat.
        rand_beats(2);
        rand_beat();
        step(1'b1, 1'b1);
        rand_beats(4);
        idle(5);

        // clr during a read leaves its four output cycles intact.
        rand_beats(4);
        rand_beat();
        step(1'b0, 1'b1);
        rand_beat();
        step(1'b1, 1'b1);
        idle(4);

        // Reset pulse at read cycle rcnt=1.
        rand_beats(4);
        idle(1);
        pulse_reset();
        rand_beats(4);
        idle(5);

        // Extremes of the signed range on every lane.
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 16; l++) begin
                b1i[l] = ((l + k) % 2) ? 11'h3FF : 11'h400;
                b1q[l] = ((l + k) % 2) ? 11'h400 : 11'h3FF;
                b2i[l] = (l % 2) ? 11'h400 : 11'h3FF;
                b2q[l] = (k % 2) ? 11'h3FF : 11'h400;
            end
            step(1'b1, 1'b0);
        end
        idle(5);

        // Random traffic with gaps and occasional clr.
        for (int i = 0; i < 400; i++) begin
            rand_beat();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
